// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment sequence checker: segment codes,
// the invalid-digit marker, FSM state encoding and the wrap-around stepper.
`default_nettype none

package seg_pkg;

    // Active-low codes, written g..a (bit6..bit0)
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [3:0] INVALID_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic logic [3:0] next_digit(
        input logic [3:0] cur,
        input logic       fwd,
        input logic [3:0] lo,
        input logic [3:0] hi
    );
        logic [3:0] nxt;
        if (fwd) begin
            nxt = (cur == hi) ? lo : cur + 4'd1;
        end else begin
            nxt = (cur == lo) ? hi : cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment pattern to digit decoder.
`default_nettype none

module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] digit_o
);

    always_comb begin
        valid_o = 1'b1;
        digit_o = INVALID_DIGIT;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_sequence_checker.sv
// Watches HEX0, predicts the next digit from step/dir and reports match or
// mismatch after a settle delay, with saturating pass/error counters.
`default_nettype none

module seg_sequence_checker
    import seg_pkg::*;
#(
    parameter int MIN_DIGIT = 1,
    parameter int MAX_DIGIT = 5,
    parameter int SETTLE    = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    input  logic             dir,
    input  logic             step,
    output logic [3:0]       expected,
    output logic [3:0]       observed,
    output logic             synced,
    output logic             match,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] c_MIN    = MIN_DIGIT[3:0];
    localparam logic [3:0] c_MAX    = MAX_DIGIT[3:0];
    localparam logic [3:0] c_SETTLE = SETTLE[3:0];

    logic       w_valid;
    logic [3:0] w_digit;
    logic       w_in_range;

    state_t           state_q, state_d;
    logic [3:0]       expected_q, expected_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       observed_q;
    logic             synced_q, synced_d;
    logic             match_q, match_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;

    seg7_decode u_decode (
        .seg_i   (seg_in),
        .valid_o (w_valid),
        .digit_o (w_digit)
    );

    assign w_in_range = w_valid && (w_digit >= c_MIN) && (w_digit <= c_MAX);

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        cnt_d      = cnt_q;
        synced_d   = synced_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        case (state_q)
            SYNC: begin
                if (w_in_range) begin
                    expected_d = w_digit;
                    synced_d   = 1'b1;
                    state_d    = TRACK;
                end
            end
            TRACK: begin
                if (step) begin
                    expected_d = next_digit(expected_q, dir, c_MIN, c_MAX);
                    cnt_d      = c_SETTLE;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A fresh step supersedes any pending compare
                if (step) begin
                    expected_d = next_digit(expected_q, dir, c_MIN, c_MAX);
                    cnt_d      = c_SETTLE;
                end else if (cnt_q == 4'd1) begin
                    if (w_valid && (w_digit == expected_q)) begin
                        match_d = 1'b1;
                        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
                        state_d = TRACK;
                    end else begin
                        mismatch_d = 1'b1;
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
                        if (w_in_range) begin
                            expected_d = w_digit;
                            state_d    = TRACK;
                        end else begin
                            expected_d = 4'd0;
                            synced_d   = 1'b0;
                            state_d    = SYNC;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            expected_q <= 4'd0;
            cnt_q      <= 4'd0;
            observed_q <= INVALID_DIGIT;
            synced_q   <= 1'b0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            pass_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            cnt_q      <= cnt_d;
            observed_q <= w_valid ? w_digit : INVALID_DIGIT;
            synced_q   <= synced_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
        end
    end

    assign expected   = expected_q;
    assign observed   = observed_q;
    assign synced     = synced_q;
    assign match      = match_q;
    assign mismatch   = mismatch_q;
    assign pass_count = pass_q;
    assign err_count  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_sequence_checker.sv
// Directed bench for seg_sequence_checker with hand-computed expectations.
`default_nettype none

module tb_seg_sequence_checker;

    localparam logic [6:0] D1    = 7'b1111001;
    localparam logic [6:0] D2    = 7'b0100100;
    localparam logic [6:0] D3    = 7'b0110000;
    localparam logic [6:0] D4    = 7'b0011001;
    localparam logic [6:0] D5    = 7'b0010010;
    localparam logic [6:0] D8    = 7'b0000000;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] JUNK  = 7'b1010101;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       dir;
    logic       step;
    logic [3:0] expected;
    logic [3:0] observed;
    logic       synced;
    logic       match;
    logic       mismatch;
    logic [7:0] pass_count;
    logic [7:0] err_count;

    int n_assert = 0;
    int n_fail   = 0;

    seg_sequence_checker #(
        .MIN_DIGIT (1),
        .MAX_DIGIT (5),
        .SETTLE    (2),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .dir        (dir),
        .step       (step),
        .expected   (expected),
        .observed   (observed),
        .synced     (synced),
        .match      (match),
        .mismatch   (mismatch),
        .pass_count (pass_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_expected"}, 32'(expected), 32'h0);
        chk({tag, "_observed"}, 32'(observed), 32'hF);
        chk({tag, "_synced"},   32'(synced),   32'h0);
        chk({tag, "_match"},    32'(match),    32'h0);
        chk({tag, "_mismatch"}, 32'(mismatch), 32'h0);
        chk({tag, "_pass"},     32'(pass_count), 32'h0);
        chk({tag, "_err"},      32'(err_count),  32'h0);
    endtask

    // Step at the next edge, then run to the cycle where the compare pulse shows
    task automatic do_step(input logic d, input logic [6:0] s);
        step   = 1'b1;
        dir    = d;
        seg_in = s;
        tick();
        step = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_pulse(input string tag, input logic m, input logic mm,
                             input logic [7:0] p, input logic [7:0] e, input logic [3:0] x);
        chk({tag, "_match"},    32'(match),      32'(m));
        chk({tag, "_mismatch"}, 32'(mismatch),   32'(mm));
        chk({tag, "_pass"},     32'(pass_count), 32'(p));
        chk({tag, "_err"},      32'(err_count),  32'(e));
        chk({tag, "_expected"}, 32'(expected),   32'(x));
    endtask

    initial begin
        reset  = 1'b1;
        seg_in = BLANK;
        dir    = 1'b1;
        step   = 1'b0;
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();
        chk("blank_synced", 32'(synced), 32'h0);

        seg_in = D1;
        tick();
        chk("sync_synced",   32'(synced),   32'h1);
        chk("sync_expected", 32'(expected), 32'h1);
        chk("sync_observed", 32'(observed), 32'h1);

        // Forward 1->2 with compare timing
        step   = 1'b1;
        dir    = 1'b1;
        seg_in = D2;
        tick();
        step = 1'b0;
        chk("s12_exp_at_step", 32'(expected), 32'h2);
        chk("s12_no_early",    32'(match),    32'h0);
        tick();
        chk("s12_no_early2",   32'(match),    32'h0);
        tick();
        chk_pulse("s12", 1'b1, 1'b0, 8'd1, 8'd0, 4'd2);
        tick();
        chk("s12_one_cycle", 32'(match), 32'h0);

        do_step(1'b1, D3);
        chk_pulse("s23", 1'b1, 1'b0, 8'd2, 8'd0, 4'd3);
        do_step(1'b1, D4);
        chk_pulse("s34", 1'b1, 1'b0, 8'd3, 8'd0, 4'd4);
        do_step(1'b1, D5);
        chk_pulse("s45", 1'b1, 1'b0, 8'd4, 8'd0, 4'd5);
        do_step(1'b1, D1);
        chk_pulse("wrap_fwd", 1'b1, 1'b0, 8'd5, 8'd0, 4'd1);
        do_step(1'b0, D5);
        chk_pulse("wrap_bwd", 1'b1, 1'b0, 8'd6, 8'd0, 4'd5);
        do_step(1'b0, D4);
        chk_pulse("s54", 1'b1, 1'b0, 8'd7, 8'd0, 4'd4);
        do_step(1'b0, D3);
        chk_pulse("s43", 1'b1, 1'b0, 8'd8, 8'd0, 4'd3);

        // Display did not follow: resync to the shown digit
        do_step(1'b1, D3);
        chk_pulse("resync", 1'b0, 1'b1, 8'd8, 8'd1, 4'd3);
        chk("resync_synced", 32'(synced), 32'h1);

        // Out-of-range digit drops sync
        do_step(1'b1, D8);
        chk_pulse("lost", 1'b0, 1'b1, 8'd8, 8'd2, 4'd0);
        chk("lost_synced",   32'(synced),   32'h0);
        chk("lost_observed", 32'(observed), 32'h8);
        step = 1'b1;
        seg_in = JUNK;
        tick();
        step = 1'b0;
        chk("junk_observed", 32'(observed), 32'hF);
        chk("junk_synced",   32'(synced),   32'h0);
        chk("junk_expected", 32'(expected), 32'h0);
        seg_in = D2;
        tick();
        chk("resync2_synced",   32'(synced),   32'h1);
        chk("resync2_expected", 32'(expected), 32'h2);

        // Back-to-back steps: one compare only
        step   = 1'b1;
        dir    = 1'b1;
        seg_in = D4;
        tick();
        chk("dbl_exp1", 32'(expected), 32'h3);
        tick();
        step = 1'b0;
        chk("dbl_exp2",  32'(expected), 32'h4);
        chk("dbl_none1", 32'({match, mismatch}), 32'h0);
        tick();
        chk("dbl_none2", 32'({match, mismatch}), 32'h0);
        tick();
        chk_pulse("dbl", 1'b1, 1'b0, 8'd9, 8'd2, 4'd4);
        tick();
        chk("dbl_after", 32'({match, mismatch}), 32'h0);

        // Reset in the middle of WAIT
        step   = 1'b1;
        seg_in = D5;
        tick();
        step  = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_state("rst_wait");
        tick();
        tick();
        chk("rst_wait_nopulse", 32'({match, mismatch}), 32'h0);
        reset = 1'b0;
        tick();
        chk("rst_release_sync", 32'(synced),   32'h1);
        chk("rst_release_exp",  32'(expected), 32'h5);

        // Error counter saturation
        for (int i = 0; i < 255; i++) begin
            do_step(1'b1, D5);
            chk("sat_pulse", 32'({match, mismatch}), 32'h1);
        end
        chk("sat_err_ff",  32'(err_count),  32'hFF);
        chk("sat_pass_0",  32'(pass_count), 32'h0);
        do_step(1'b1, D5);
        chk_pulse("sat_hold", 1'b0, 1'b1, 8'd0, 8'hFF, 4'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
